// File: rtl/act_pkg.sv
// Shared types and elaboration helpers for the streaming activation layer.
//   act_mode_t   : activation selector carried alongside each vector
//   state_t      : control FSM states of activation_layer_stream
//   clip_ceiling : clipped-ReLU ceiling, saturated to the largest positive element
package act_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Evaluated in 64 bits so CLIP_INT << NFRAC cannot wrap before the clamp.
  function automatic longint clip_ceiling(input int unsigned width, input int unsigned nfrac,
                                          input int unsigned clip_int);
    longint ceil_raw;
    longint max_pos;
    ceil_raw = longint'(clip_int) << nfrac;
    max_pos  = (longint'(1) << (width - 1)) - 1;
    return (ceil_raw < max_pos) ? ceil_raw : max_pos;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-element activation function, purely combinational.
// Ports:
//   x_i    : signed fixed-point input element
//   mode_i : activation selector
//   y_o    : activated element, same width as x_i
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter longint      CEIL       = 192
) (
  input  logic [WIDTH-1:0] x_i,
  input  act_mode_t        mode_i,
  output logic [WIDTH-1:0] y_o
);

  localparam logic signed [WIDTH-1:0] CeilS = WIDTH'(CEIL);

  logic signed [WIDTH-1:0] xs;
  logic                    neg;

  assign xs  = $signed(x_i);
  assign neg = x_i[WIDTH-1];

  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_LINEAR: y_o = x_i;
      ACT_RELU: begin
        if (neg) y_o = '0;
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, so small negatives settle at -1.
        if (neg) y_o = $unsigned(xs >>> LEAK_SHIFT);
      end
      ACT_CLIP: begin
        if (neg) begin
          y_o = '0;
        end else if (xs > CeilS) begin
          y_o = $unsigned(CeilS);
        end
      end
      default: y_o = x_i;
    endcase
  end

endmodule

// File: rtl/activation_layer_stream.sv
// Streaming activation layer: captures a SIZE-element signed vector with its activation mode,
// processes LANES elements per cycle over SIZE/LANES beats and holds the registered result
// until downstream accepts it. Valid/ready on both sides so back-pressure reaches upstream.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in_valid     : input vector valid
//   in_ready     : block can accept a vector this cycle
//   in_mode      : 0 linear, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU (captured with the vector)
//   input_data   : SIZE x WIDTH packed vector, element i at [i*WIDTH +: WIDTH]
//   out_valid    : output_data holds a complete result
//   out_ready    : downstream accepts the result
//   output_data  : registered SIZE x WIDTH result vector
//   busy         : a vector is being processed or held
module activation_layer_stream
  import act_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned NFRAC      = 5,
  parameter int unsigned SIZE       = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CLIP_INT   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [SIZE*WIDTH-1:0] input_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WIDTH-1:0] output_data,
  output logic                  busy
);

  localparam int unsigned Beats = SIZE / LANES;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned LaneW = LANES * WIDTH;
  localparam longint      Ceil  = clip_ceiling(WIDTH, NFRAC, CLIP_INT);

  if (LANES == 0 || (SIZE % LANES) != 0) begin : g_bad_lanes
    $error("activation_layer_stream: SIZE must be a non-zero multiple of LANES");
  end
  if (NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("activation_layer_stream: NFRAC must be below WIDTH");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > WIDTH - 1) begin : g_bad_leak
    $error("activation_layer_stream: LEAK_SHIFT must be in 1..WIDTH-1");
  end

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  act_mode_t             mode_q, mode_d;
  logic [SIZE*WIDTH-1:0] buf_q, buf_d;
  logic [SIZE*WIDTH-1:0] out_q, out_d;

  logic [LaneW-1:0] lane_x;
  logic [LaneW-1:0] lane_y;

  // Select the current beat's slice of the captured vector.
  always_comb begin
    lane_x = '0;
    for (int b = 0; b < Beats; b++) begin
      if (cnt_q == CntW'(b)) lane_x = buf_q[b*LaneW +: LaneW];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    act_lane #(
      .WIDTH     (WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CEIL      (Ceil)
    ) u_lane (
      .x_i   (lane_x[l*WIDTH +: WIDTH]),
      .mode_i(mode_q),
      .y_o   (lane_y[l*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          buf_d   = input_data;
          mode_d  = act_mode_t'(in_mode);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int b = 0; b < Beats; b++) begin
          if (cnt_q == CntW'(b)) out_d[b*LaneW +: LaneW] = lane_y;
        end
        if (cnt_q == CntW'(Beats - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_HOLD: begin
        // Result leaves and, if offered, the next vector enters on the same edge.
        if (out_ready) begin
          if (in_valid) begin
            buf_d   = input_data;
            mode_d  = act_mode_t'(in_mode);
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= ACT_LINEAR;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid   = (state_q == S_HOLD);
  assign busy        = (state_q == S_RUN) || (state_q == S_HOLD);
  assign output_data = out_q;

endmodule

// File: tb/tb_activation_layer_stream.sv
// Bench for activation_layer_stream with WIDTH=10, NFRAC=5, SIZE=8, LANES=2.
// A second instance with CLIP_INT=20 shares the stimulus to cover the saturated ceiling.
module tb_activation_layer_stream;

  localparam int W = 10;
  localparam int N = 8;

  typedef logic [N*W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_mode = 2'd0;
  vec_t       input_data = '0;

  logic in_ready, out_valid, busy;
  vec_t output_data;
  logic in_ready_b, out_valid_b, busy_b;
  vec_t output_data_b;

  activation_layer_stream #(
    .WIDTH(10), .NFRAC(5), .SIZE(8), .LANES(2), .LEAK_SHIFT(3), .CLIP_INT(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .input_data(input_data), .out_valid(out_valid), .out_ready(out_ready),
    .output_data(output_data), .busy(busy)
  );

  activation_layer_stream #(
    .WIDTH(10), .NFRAC(5), .SIZE(8), .LANES(2), .LEAK_SHIFT(3), .CLIP_INT(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_mode(in_mode),
    .input_data(input_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .output_data(output_data_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_pop = 0;

  vec_t sb[$];
  vec_t exp_v;
  logic hold_pend = 1'b0;
  vec_t hold_data;

  function automatic logic [W-1:0] ref_act(input logic [W-1:0] x, input logic [1:0] m,
                                           input int ceil);
    logic signed [W-1:0] s;
    logic [W-1:0] r;
    s = x;
    r = x;
    if (m == 2'd1) begin
      if (s < 0) r = '0;
    end else if (m == 2'd2) begin
      if (s < 0) r = s >>> 3;
    end else if (m == 2'd3) begin
      if (s < 0) r = '0;
      else if (int'(s) > ceil) r = W'(ceil);
    end
    return r;
  endfunction

  function automatic vec_t ref_vec(input vec_t v, input logic [1:0] m, input int ceil);
    vec_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = ref_act(v[i*W +: W], m, ceil);
    return r;
  endfunction

  function automatic vec_t pack(input int v[N]);
    vec_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  // Scoreboard and hold-stability monitor; handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || output_data !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: out_valid=%b data=%h required out_valid=1 data=%h",
                   out_valid, output_data, hold_data);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = output_data;
      if (in_valid && in_ready) sb.push_back(ref_vec(input_data, in_mode, 192));
      if (out_valid && out_ready) begin
        checks++;
        n_pop++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h required no output", output_data);
        end else begin
          exp_v = sb.pop_front();
          if (output_data !== exp_v) begin
            errors++;
            $display("FAIL sb_data: got %h required %h", output_data, exp_v);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input logic [1:0] m);
    input_data = v;
    in_mode    = m;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || output_data !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b data=%h required 0 0 1 0",
               out_valid, busy, in_ready, output_data);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_relu();
    int a[N];
    int e[N];
    int c;
    a = '{-32, 96, 0, -1, 511, -512, 5, -5};
    e = '{0, 96, 0, 0, 511, 0, 5, 0};
    out_ready = 1'b1;
    send(pack(a), 2'd1);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL relu_run_flags: ready=%b busy=%b required 0 1", in_ready, busy);
    end
    wait_valid(c);
    checks++;
    if (c !== 4) begin
      errors++;
      $display("FAIL relu_latency: got %0d required 4", c);
    end
    checks++;
    if (output_data !== pack(e)) begin
      errors++;
      $display("FAIL relu_data: got %h required %h", output_data, pack(e));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL relu_return_idle: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_leaky();
    int a[N];
    int e[N];
    int c;
    a = '{-32, 96, 0, -1, 511, -512, 5, -5};
    e = '{-4, 96, 0, -1, 511, -64, 5, -1};
    out_ready = 1'b1;
    send(pack(a), 2'd2);
    wait_valid(c);
    checks++;
    if (c !== 4 || output_data !== pack(e)) begin
      errors++;
      $display("FAIL leaky_data: cyc=%0d got %h required cyc=4 %h", c, output_data, pack(e));
    end
    tick();
  endtask

  task automatic test_clip();
    int a[N];
    int e[N];
    int e20[N];
    int c;
    a   = '{224, 192, 191, -32, 511, 0, 100, -1};
    e   = '{192, 192, 191, 0, 192, 0, 100, 0};
    e20 = '{224, 192, 191, 0, 511, 0, 100, 0};
    out_ready = 1'b1;
    send(pack(a), 2'd3);
    wait_valid(c);
    checks++;
    if (c !== 4 || output_data !== pack(e)) begin
      errors++;
      $display("FAIL clip_data: cyc=%0d got %h required cyc=4 %h", c, output_data, pack(e));
    end
    checks++;
    if (out_valid_b !== 1'b1 || output_data_b !== pack(e20)) begin
      errors++;
      $display("FAIL clip20_data: valid=%b got %h required 1 %h",
               out_valid_b, output_data_b, pack(e20));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int a[N];
    int b[N];
    int e2[N];
    int c;
    vec_t snap;
    a  = '{-32, 96, 0, -1, 511, -512, 5, -5};
    b  = '{224, 192, 191, -32, 511, 0, 100, -1};
    e2 = '{224, 192, 191, -4, 511, 0, 100, -1};
    out_ready = 1'b0;
    send(pack(a), 2'd1);
    wait_valid(c);
    snap = output_data;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || output_data !== snap) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b ready=%b data=%h required 1 0 %h",
                 i, out_valid, in_ready, output_data, snap);
      end
      tick();
    end
    input_data = pack(b);
    in_mode    = 2'd2;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ready_follow: got %b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_mode  = 2'd0;  // ignored: the captured mode governs this vector
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_accept: valid=%b busy=%b ready=%b required 0 1 0",
               out_valid, busy, in_ready);
    end
    tick();
    in_mode = 2'd3;
    wait_valid(c);
    checks++;
    if (c !== 3 || output_data !== pack(e2)) begin
      errors++;
      $display("FAIL b2b_data: cyc=%0d got %h required cyc=3 %h", c, output_data, pack(e2));
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int a[N];
    int b[N];
    int e[N];
    int c;
    a = '{-32, 96, 0, -1, 511, -512, 5, -5};
    b = '{224, 192, 191, -32, 511, 0, 100, -1};
    e = '{192, 192, 191, 0, 192, 0, 100, 0};
    out_ready = 1'b1;
    send(pack(a), 2'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || output_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h ready=%b required 0 0 0 1",
               out_valid, busy, output_data, in_ready);
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    send(pack(b), 2'd3);
    wait_valid(c);
    checks++;
    if (c !== 4 || output_data !== pack(e)) begin
      errors++;
      $display("FAIL post_reset_data: cyc=%0d got %h required cyc=4 %h", c, output_data, pack(e));
    end
    tick();
  endtask

  task automatic test_streaming();
    int sent;
    int cyc;
    int pop0;
    sent = 0;
    cyc  = 0;
    pop0 = n_pop;
    while (sent < 20 && cyc < 2000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) input_data[i*W +: W] = W'($urandom_range(0, 1023));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (sent != 20 || sb.size() != 0 || (n_pop - pop0) != 20) begin
      errors++;
      $display("FAIL stream_count: sent=%0d pending=%0d outputs=%0d required 20 0 20",
               sent, sb.size(), n_pop - pop0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_relu();
    test_leaky();
    test_clip();
    test_back_to_back();
    test_reset_mid_run();
    test_streaming();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_layer_stream.md
Name: activation_layer_stream

Overview:
Parametrised, handshaked successor to the combinational-plus-register ReLU layer. It accepts a SIZE-element fixed-point vector and applies a run-time-selected activation: linear, ReLU, leaky ReLU (arithmetic shift) or clipped ReLU. The vector is processed LANES elements per cycle and presented as a registered output vector. It sits between dense/RNN cell stages and uses a valid/ready handshake on both sides, so back-pressure propagates upstream.

Parameters:
WIDTH, 10, total bits of each signed fixed-point element
NFRAC, 5, fractional bits (0 <= NFRAC < WIDTH)
SIZE, 32, elements per vector
LANES, 4, elements processed per cycle; SIZE % LANES == 0 (elaboration-time assertion)
LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT (1..WIDTH-1)
CLIP_INT, 6, clipped-ReLU ceiling in integer units (ceiling = CLIP_INT * 2^NFRAC)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector this cycle
in_mode  input  2  0 linear, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU; sampled with the vector
input_data  input  SIZE x WIDTH signed  input vector
out_valid  output  1  output_data holds a complete result
out_ready  input  1  downstream accepts the result
output_data  output  SIZE x WIDTH signed  registered result vector
busy  output  1  high in RUN or HOLD

Behaviour:
- Reset (async assert, sync release): state IDLE, beat counter 0, out_valid 0, output_data all 0, busy 0, in_ready 1 after reset.
- BEATS = SIZE/LANES. Beat counter width = clog2(BEATS), minimum 1.
- FSM:
  - IDLE: in_ready=1. On in_valid, capture input_data and in_mode into the input buffer, clear the counter, go to RUN.
  - RUN: each cycle, process lanes [cnt*LANES +: LANES] from the buffer into the output register slots, then cnt++. On the cycle cnt==BEATS-1, go to HOLD. in_ready=0.
  - HOLD: out_valid=1. output_data stays stable until out_ready. in_ready=out_ready.
    - out_ready & in_valid: result consumed and new vector captured in the same cycle; go to RUN.
    - out_ready & !in_valid: go to IDLE.
- Latency: accept at edge N. out_valid rises after edge N+BEATS. With LANES==SIZE, out_valid rises one cycle after accept.
- Throughput: one vector per BEATS+1 cycles when out_ready is held high.
- Per-element function, x signed WIDTH:
  - Mode 0: y=x.
  - Mode 1: y = x[WIDTH-1] ? 0 : x.
  - Mode 2: y = x[WIDTH-1] ? (x >>> LEAK_SHIFT) : x. Arithmetic shift floors toward -inf, so -1 stays -1.
  - Mode 3: y = x<0 ? 0 : min(x, CEIL), where CEIL = min(CLIP_INT<<NFRAC, 2^(WIDTH-1)-1). Compute CEIL at elaboration in a width large enough to avoid overflow.
  - No result exceeds WIDTH bits. Modes 0/1/2 cannot overflow; mode 3 saturates.
- Between HOLD→RUN, slots not yet rewritten may briefly hold stale values. output_data is only meaningful while out_valid=1.
- in_mode changes during RUN/HOLD are ignored; only the captured mode is used.
- rst_n low mid-RUN or mid-HOLD aborts the vector; no partial result is ever flagged valid.
- out_valid never drops without out_ready; output_data never changes while out_valid && !out_ready.

Decomposition:
- Package act_pkg:
  - act_mode_t enum: ACT_LINEAR, ACT_RELU, ACT_LEAKY, ACT_CLIP
  - state_t enum: S_IDLE, S_RUN, S_HOLD
  - function clip_ceiling(WIDTH, NFRAC, CLIP_INT)
- Sub-module act_lane: purely combinational single-element function (x, mode → y), instantiated LANES times. The top level holds the FSM, buffers, counter and lane muxing.

Test Plan:
All scenarios use WIDTH=10, NFRAC=5, SIZE=8, LANES=2 (BEATS=4), LEAK_SHIFT=3, CLIP_INT=6.
- ReLU: vector {-32,96,0,-1,511,-512,5,-5}, mode 1, out_ready=1 → out_valid 4 cycles after accept with {0,96,0,0,511,0,5,0}; in_ready low during RUN.
- Leaky: same vector, mode 2 → {-4,96,0,-1,511,-64,5,-1}.
- Clip: {224,192,191,-32,511,0,100,-1}, mode 3 → {192,192,191,0,192,0,100,0}. Also CLIP_INT=20 variant → ceiling 511, {224..} passes unchanged.
- Back-pressure: hold out_ready=0 for 10 cycles in HOLD → output_data and out_valid stable, in_ready=0. Then assert out_ready with in_valid=1 → same-cycle consume+accept, next result 4 cycles later. Mode change during RUN is ignored.
- Reset: drop rst_n at beat 2 of RUN → out_valid=0, output_data=0, busy=0 immediately (asynchronous). After release, a new vector completes normally.
- Streaming: 20 random vectors with random modes and random out_ready/in_valid → scoreboard match, no drop or duplicate, every output equals reference model.
